// File: rtl/mp3_play_time_counter.sv
// Elapsed-play-time counter: packed-BCD mm:ss driven by 1 s ticks, with a
// track-length match interrupt and an Avalon-MM register interface.
module mp3_play_time_counter #(
  parameter logic [7:0] MAX_MIN_BCD = 8'h99
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        tick_in,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  output logic        irq,
  output logic [15:0] time_bcd
);

  logic        tick_q;
  logic        tick_evt;
  logic        irq_en;
  logic        run;
  logic        match_occurred;
  logic        wrap_occurred;
  logic        upd_q;
  logic [15:0] limit;

  logic        wr;
  logic        wr_status;
  logic        wr_control;
  logic        wr_time;
  logic        wr_limit;
  logic        clear;

  logic [15:0] inc;
  logic        at_end;
  logic [15:0] time_nxt;
  logic        time_upd;
  logic        wrap_evt;
  logic        match_evt;
  logic [15:0] rd_mux;

  function automatic logic bcd_legal(input logic [15:0] v);
    return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd5) && (v[11:8] <= 4'd9) &&
           (v[15:12] <= 4'd9) && (v[15:8] <= MAX_MIN_BCD);
  endfunction

  assign tick_evt   = tick_in & ~tick_q;
  assign wr         = chipselect & ~write_n;
  assign wr_status  = wr && (address == 3'd0);
  assign wr_control = wr && (address == 3'd1);
  assign wr_time    = wr && (address == 3'd2);
  assign wr_limit   = wr && (address == 3'd3);
  assign clear      = wr_control & writedata[2];

  // Match is judged one cycle after the count changes, so a count parked on
  // the limit does not re-raise the flag after software clears it.
  assign match_evt = upd_q && (limit != '0) && (time_bcd == limit);
  assign irq       = match_occurred & irq_en;

  always_comb begin
    inc    = time_bcd;
    at_end = 1'b0;
    if (time_bcd[3:0] != 4'd9) begin
      inc[3:0] = time_bcd[3:0] + 4'd1;
    end else begin
      inc[3:0] = '0;
      if (time_bcd[7:4] != 4'd5) begin
        inc[7:4] = time_bcd[7:4] + 4'd1;
      end else begin
        inc[7:4] = '0;
        if (time_bcd[15:8] == MAX_MIN_BCD) begin
          inc[15:8] = '0;
          at_end    = 1'b1;
        end else if (time_bcd[11:8] != 4'd9) begin
          inc[11:8] = time_bcd[11:8] + 4'd1;
        end else begin
          inc[11:8]  = '0;
          inc[15:12] = time_bcd[15:12] + 4'd1;
        end
      end
    end
  end

  always_comb begin
    time_nxt = time_bcd;
    time_upd = 1'b0;
    wrap_evt = 1'b0;
    if (clear) begin
      time_nxt = '0;
      time_upd = 1'b1;
    end else if (wr_time && bcd_legal(writedata)) begin
      time_nxt = writedata;
      time_upd = 1'b1;
    end else if (tick_evt && run) begin
      time_nxt = inc;
      time_upd = 1'b1;
      wrap_evt = at_end;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      3'd0:    rd_mux = {13'b0, wrap_occurred, match_occurred, run};
      3'd1:    rd_mux = {14'b0, run, irq_en};
      3'd2:    rd_mux = time_bcd;
      3'd3:    rd_mux = limit;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tick_q         <= 1'b0;
      upd_q          <= 1'b0;
      time_bcd       <= '0;
      limit          <= '0;
      irq_en         <= 1'b0;
      run            <= 1'b0;
      match_occurred <= 1'b0;
      wrap_occurred  <= 1'b0;
      readdata       <= '0;
    end else begin
      tick_q         <= tick_in;
      upd_q          <= time_upd;
      readdata       <= rd_mux;
      if (time_upd)
        time_bcd <= time_nxt;
      match_occurred <= (match_occurred & ~wr_status) | match_evt;
      wrap_occurred  <= (wrap_occurred & ~wr_status) | wrap_evt;
      if (wr_control) begin
        irq_en <= writedata[0];
        run    <= writedata[1];
      end
      if (wr_limit && bcd_legal(writedata))
        limit <= writedata;
    end
  end

endmodule

// File: tb/tb_mp3_play_time_counter.sv
// Bench for mp3_play_time_counter: seconds-based reference model checked every
// cycle, plus directed literal expectations and a randomized register/tick phase.
module tb_mp3_play_time_counter;

  localparam int MAXM  = 99;
  localparam int TOTAL = (MAXM + 1) * 60;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        tick_in;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic        irq;
  logic [15:0] time_bcd;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mp3_play_time_counter #(.MAX_MIN_BCD(8'h99)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .tick_in   (tick_in),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .irq       (irq),
    .time_bcd  (time_bcd)
  );

  // Reference state: elapsed time as a plain number of seconds.
  int          m_secs  = 0;
  bit          m_run   = 0;
  bit          m_irqen = 0;
  bit          m_match = 0;
  bit          m_wrap  = 0;
  bit          m_upd   = 0;
  bit          m_tq    = 0;
  logic [15:0] m_limit = '0;
  logic [15:0] m_rd    = '0;
  bit          started = 0;

  function automatic logic [15:0] to_bcd(input int s);
    int m, x;
    logic [3:0] a, b, c, d;
    m = s / 60;
    x = s % 60;
    a = 4'(m / 10);
    b = 4'(m % 10);
    c = 4'(x / 10);
    d = 4'(x % 10);
    return {a, b, c, d};
  endfunction

  function automatic bit legal(input logic [15:0] v);
    int d3, d2, d1, d0;
    d3 = int'(v[15:12]);
    d2 = int'(v[11:8]);
    d1 = int'(v[7:4]);
    d0 = int'(v[3:0]);
    return (d0 <= 9) && (d1 <= 5) && (d2 <= 9) && (d3 <= 9) && (d3 * 10 + d2 <= MAXM);
  endfunction

  function automatic int from_bcd(input logic [15:0] v);
    return (int'(v[15:12]) * 10 + int'(v[11:8])) * 60 + int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic void check(input string name, input logic [15:0] act,
                                input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endfunction

  always @(posedge clk) begin : model
    bit wr, tev, mset, wset, clr, stclr;
    started = 1;
    if (!reset_n) begin
      m_secs = 0; m_run = 0; m_irqen = 0; m_match = 0; m_wrap = 0;
      m_upd = 0; m_tq = 0; m_limit = '0; m_rd = '0;
    end else begin
      case (address)
        3'd0:    m_rd = {13'b0, m_wrap, m_match, m_run};
        3'd1:    m_rd = {14'b0, m_run, m_irqen};
        3'd2:    m_rd = to_bcd(m_secs);
        3'd3:    m_rd = m_limit;
        default: m_rd = '0;
      endcase
      mset  = m_upd && (m_limit != 0) && (to_bcd(m_secs) == m_limit);
      tev   = tick_in && !m_tq;
      m_tq  = tick_in;
      wr    = chipselect && !write_n;
      clr   = wr && address == 3'd1 && writedata[2];
      stclr = wr && address == 3'd0;
      wset  = 0;
      m_upd = 0;
      if (clr) begin
        m_secs = 0;
        m_upd  = 1;
      end else if (wr && address == 3'd2 && legal(writedata)) begin
        m_secs = from_bcd(writedata);
        m_upd  = 1;
      end else if (tev && m_run) begin
        if (m_secs == TOTAL - 1) wset = 1;
        m_secs = (m_secs + 1) % TOTAL;
        m_upd  = 1;
      end
      m_match = (m_match && !stclr) || mset;
      m_wrap  = (m_wrap && !stclr) || wset;
      if (wr && address == 3'd1) begin
        m_irqen = writedata[0];
        m_run   = writedata[1];
      end
      if (wr && address == 3'd3 && legal(writedata)) m_limit = writedata;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("time_bcd", time_bcd, to_bcd(m_secs));
      check("irq", {15'b0, irq}, {15'b0, m_match && m_irqen});
      check("readdata", readdata, m_rd);
    end
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [15:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    cyc();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd_reg(input logic [2:0] a, output logic [15:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    cyc();
    d = readdata;
    chipselect = 1'b0;
  endtask

  task automatic pulse();
    tick_in = 1'b1;
    cyc();
    tick_in = 1'b0;
    cyc();
  endtask

  initial begin
    logic [15:0] r;
    logic [15:0] wd;
    reset_n = 1'b0; tick_in = 1'b0; address = '0; chipselect = 1'b0;
    write_n = 1'b1; writedata = '0;

    // Reset and ticks while stopped
    cyc(); cyc();
    check("rst_readdata", readdata, 16'h0000);
    check("rst_irq", {15'b0, irq}, 16'h0000);
    check("rst_time", time_bcd, 16'h0000);
    reset_n = 1'b1;
    repeat (3) pulse();
    check("stopped_time", time_bcd, 16'h0000);

    // Counting and carries
    wr_reg(3'd1, 16'h0002);
    repeat (61) pulse();
    check("count_61", time_bcd, 16'h0101);
    wr_reg(3'd2, 16'h0959);
    pulse();
    check("carry_min", time_bcd, 16'h1000);
    tick_in = 1'b1;
    repeat (10) cyc();
    tick_in = 1'b0;
    cyc();
    check("held_tick", time_bcd, 16'h1001);

    // Wrap
    wr_reg(3'd2, 16'h9959);
    pulse();
    check("wrap_time", time_bcd, 16'h0000);
    rd_reg(3'd0, r);
    check("wrap_status", r, 16'h0005);
    wr_reg(3'd0, 16'h0000);
    rd_reg(3'd0, r);
    check("status_clr", r, 16'h0001);

    // Match interrupt
    wr_reg(3'd3, 16'h0003);
    wr_reg(3'd1, 16'h0003);
    wr_reg(3'd2, 16'h0000);
    repeat (2) pulse();
    tick_in = 1'b1;
    cyc();
    check("match_time", time_bcd, 16'h0003);
    check("match_irq_early", {15'b0, irq}, 16'h0000);
    tick_in = 1'b0;
    cyc();
    check("match_irq", {15'b0, irq}, 16'h0001);
    wr_reg(3'd0, 16'h0000);
    check("match_irq_clr", {15'b0, irq}, 16'h0000);
    wr_reg(3'd3, 16'h0000);
    wr_reg(3'd2, 16'h0000);
    for (int i = 0; i < 5; i++) begin
      pulse();
      check("limit0_irq", {15'b0, irq}, 16'h0000);
    end

    // Same-edge collisions and illegal TIME write
    tick_in = 1'b1;
    wr_reg(3'd1, 16'h0006);
    tick_in = 1'b0;
    check("clear_vs_tick", time_bcd, 16'h0000);
    cyc();
    tick_in = 1'b1;
    wr_reg(3'd2, 16'h0500);
    tick_in = 1'b0;
    check("time_vs_tick", time_bcd, 16'h0500);
    cyc();
    wr_reg(3'd2, 16'h0060);
    check("illegal_time", time_bcd, 16'h0500);

    // Mid-operation reset
    wr_reg(3'd2, 16'h0042);
    wr_reg(3'd1, 16'h0002);
    reset_n = 1'b0;
    cyc();
    check("midrst_time", time_bcd, 16'h0000);
    check("midrst_readdata", readdata, 16'h0000);
    reset_n = 1'b1;
    rd_reg(3'd0, r);
    check("midrst_status", r, 16'h0000);

    // Randomized register traffic and ticks
    for (int i = 0; i < 3000; i++) begin
      int a;
      reset_n    = ($urandom_range(0, 199) != 0);
      tick_in    = ($urandom_range(0, 2) == 0);
      chipselect = $urandom_range(0, 1);
      write_n    = $urandom_range(0, 1);
      a = $urandom_range(0, 9);
      address = (a > 7) ? 3'd2 : 3'(a);
      wd = 16'($urandom);
      case ($urandom_range(0, 3))
        0: wd = to_bcd((m_secs + $urandom_range(0, 3)) % TOTAL);
        1: wd = to_bcd(TOTAL - 1 - $urandom_range(0, 2));
        2: wd = to_bcd($urandom_range(0, TOTAL - 1));
        default: ;
      endcase
      if (address == 3'd1) begin
        wd = 16'($urandom);
        if ($urandom_range(0, 3) != 0) wd[1] = 1'b1;
        wd[2] = ($urandom_range(0, 15) == 0);
      end
      writedata = wd;
      cyc();
    end

    chipselect = 1'b0; write_n = 1'b1; tick_in = 1'b0;
    cyc();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
